// File: rtl/mult_ft_pkg.sv
// Shared types and helpers for the fault-tolerant sequential multiplier:
// FSM state encoding, width helpers and a width-generic mod-3 reduction.
package mult_ft_pkg;

  typedef enum logic [2:0] {IDLE, CALC, CHECK, RETRY, DONE} state_t;

  // Widest vector mod3() reduces; narrower inputs are zero-extended.
  localparam int MOD3_MAX_W = 64;

  function automatic int unsigned idx_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned w);
    return 2 * w;
  endfunction

  // Bit pairs carry weights 1 and 2 because 4 == 1 (mod 3).
  function automatic logic [1:0] mod3(input logic [MOD3_MAX_W-1:0] x);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < MOD3_MAX_W; i += 2)
      s = s + 8'(x[i]) + 8'({x[i+1], 1'b0});
    return 2'(s % 8'd3);
  endfunction

endpackage

// File: rtl/mult_ft_residue3.sv
// Combinational mod-3 residue of a W-bit unsigned value.
module mult_ft_residue3
  import mult_ft_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  output logic [1:0]   r
);

  assign r = mod3(MOD3_MAX_W'(x));

endmodule

// File: rtl/mult_seq_ft.sv
// Sequential shift-add multiplier with mod-3 residue checking, bounded
// recomputation on mismatch, valid/ready handshake and a fault-injection hook.
module mult_seq_ft
  import mult_ft_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         inj,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               err,
  output logic               retried
);

  localparam int AW = acc_w(WIDTH);
  localparam int IW = idx_w(WIDTH);
  localparam int RW = idx_w(MAX_RETRY + 1);

  state_t          state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]      inj_r, ra, rb, ra_c, rb_c, racc, rexp;
  logic [3:0]      rprod;
  logic [AW-1:0]   acc, acc_step;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   rcnt;
  logic            last, flip, match, retry_ok;

  mult_ft_residue3 #(.W(WIDTH)) u_res_a   (.x(a),   .r(ra_c));
  mult_ft_residue3 #(.W(WIDTH)) u_res_b   (.x(b),   .r(rb_c));
  mult_ft_residue3 #(.W(AW))    u_res_acc (.x(acc), .r(racc));

  assign last     = (idx == IW'(WIDTH - 1));
  assign flip     = inj_r[1] || (inj_r[0] && (rcnt == '0));
  // The injected flip lands only on the final partial-product step.
  assign acc_step = (acc + (b_r[idx] ? (AW'(a_r) << idx) : '0)) ^ AW'(flip && last);

  assign rprod    = {2'b00, ra} * {2'b00, rb};
  assign rexp     = (rprod >= 4'd3) ? 2'(rprod - 4'd3) : rprod[1:0];
  assign match    = (racc == rexp);
  assign retry_ok = (rcnt != RW'(MAX_RETRY));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = CALC;
      CALC:    if (last) nxt = CHECK;
      CHECK:   nxt = (match || !retry_ok) ? DONE : RETRY;
      RETRY:   nxt = CALC;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      inj_r   <= '0;
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      idx     <= '0;
      rcnt    <= '0;
      p       <= '0;
      err     <= 1'b0;
      retried <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          inj_r   <= inj;
          ra      <= ra_c;
          rb      <= rb_c;
          acc     <= '0;
          idx     <= '0;
          rcnt    <= '0;
          retried <= 1'b0;
        end
        CALC: begin
          acc <= acc_step;
          idx <= idx + 1'b1;
        end
        CHECK: begin
          if (!match && retry_ok) begin
            rcnt <= rcnt + 1'b1;
          end else begin
            p   <= acc;
            err <= !match;
          end
        end
        RETRY: begin
          acc     <= '0;
          idx     <= '0;
          retried <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ft.sv
// Randomized and directed bench for mult_seq_ft against an arithmetic reference model.
module tb_mult_seq_ft;

  localparam int W  = 4;
  localparam int MR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv, ir, ov, ordy, err4, ret4;
  logic [3:0]  a4, b4;
  logic [1:0]  inj4;
  logic [7:0]  p4;

  logic        iv8, ir8, ov8, ordy8, err8, ret8;
  logic [7:0]  a8, b8;
  logic [1:0]  inj8;
  logic [15:0] p8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mult_seq_ft #(.WIDTH(W), .MAX_RETRY(MR)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a4), .b(b4),
    .inj(inj4), .out_valid(ov), .out_ready(ordy), .p(p4), .err(err4), .retried(ret4)
  );

  mult_seq_ft #(.WIDTH(8), .MAX_RETRY(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .inj(inj8), .out_valid(ov8), .out_ready(ordy8), .p(p8), .err(err8), .retried(ret8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Attempt k is corrupted when inj[1] is set, or inj[0] is set and k is 0.
  task automatic model(input int a, input int b, input logic [1:0] inj,
                       output longint ep, output bit ee, output bit er, output int lat);
    int  k;
    bit  bad;
    bad = 1'b0;
    for (k = 0; k <= MR; k++) begin
      bad = inj[1] || (inj[0] && k == 0);
      if (!bad || k == MR) break;
    end
    ep  = (longint'(a) * longint'(b)) ^ longint'(bad);
    ee  = bad;
    er  = (k > 0);
    lat = (k + 1) * (W + 2);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] inj,
                      input int stall, input bit busy_iv);
    int     cyc;
    longint ep;
    bit     ee, er;
    int     el;
    model(int'(a), int'(b), inj, ep, ee, er, el);
    cyc = 0;
    while (!ir && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("idle_before", ir, 1);
    iv = 1'b1; a4 = a; b4 = b; inj4 = inj; ordy = (stall == 0);
    @(posedge clk); #1;
    a4 = 4'($urandom); b4 = 4'($urandom); inj4 = 2'($urandom); iv = busy_iv;
    check("busy_in_ready", ir, 0);
    cyc = 1;
    while (!ov && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, el);
    check("p", p4, ep);
    check("err", err4, ee);
    check("retried", ret4, er);
    check("done_in_ready", ir, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", ov, 1);
      check("stall_p", p4, ep);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    check("handoff_valid", ov, 0);
    check("handoff_ready", ir, 1);
  endtask

  initial begin
    int seen;
    int cyc;
    iv = 0; a4 = 0; b4 = 0; inj4 = 0; ordy = 0;
    iv8 = 0; a8 = 0; b8 = 0; inj8 = 0; ordy8 = 0;
    #12;
    check("rst_in_ready", ir, 1);
    check("rst_out_valid", ov, 0);
    check("rst_p", p4, 0);
    check("rst_err", err4, 0);
    check("rst_retried", ret4, 0);
    check("rst8_p", p8, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run4(4'd15, 4'd15, 2'b00, 0, 1'b0);
    run4(4'd0,  4'd9,  2'b00, 0, 1'b1);
    run4(4'd9,  4'd0,  2'b00, 0, 1'b1);
    run4(4'd7,  4'd6,  2'b01, 0, 1'b0);
    run4(4'd7,  4'd6,  2'b10, 2, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] ij;
      ij = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ij = 2'b00;
      run4(4'($urandom), 4'($urandom), ij, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Width-8 operation with a stalled consumer
    ordy8 = 1'b0;
    iv8 = 1'b1; a8 = 8'd255; b8 = 8'd255; inj8 = 2'b00;
    @(posedge clk); #1;
    iv8 = 1'b0;
    cyc = 1;
    while (!ov8 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("w8_latency", cyc, 10);
    check("w8_p", p8, 65025);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check("w8_stall_valid", ov8, 1);
      check("w8_stall_p", p8, 65025);
      check("w8_stall_ready", ir8, 0);
    end
    ordy8 = 1'b1;
    @(posedge clk); #1;
    check("w8_handoff_valid", ov8, 0);
    check("w8_handoff_ready", ir8, 1);

    // Asynchronous reset mid-CALC
    run4(4'd5, 4'd5, 2'b00, 0, 1'b0);
    iv = 1'b1; a4 = 4'd7; b4 = 4'd6; inj4 = 2'b00; ordy = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", ov, 0);
    check("arst_in_ready", ir, 1);
    check("arst_p", p4, 0);
    check("arst_err", err4, 0);
    check("arst_retried", ret4, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov) seen++;
    end
    check("arst_no_valid", seen, 0);
    run4(4'd3, 4'd5, 2'b00, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_seq_ft.md
# mult_seq_ft

Sequential, width-parametrised unsigned multiplier with built-in fault detection and recovery. It computes an iterative shift-add product and checks it against a mod-3 residue of the operands. On a mismatch it recomputes, up to a bounded retry count, and flags an error if every attempt fails. It extends the fixed 4x4 combinational fault-resilient multipliers to arbitrary width, with a valid/ready handshake and a fault-injection hook for verification.

## Interface
- WIDTH, 4: operand width in bits; must be at least 2.
- MAX_RETRY, 1: recomputations allowed after the first failed check; must be at least 0.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a/b are valid
- in_ready  out  1  block accepts operands; high exactly in IDLE
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- inj  in  2  test hook, sampled at accept; bit0 corrupts attempt 0, bit1 corrupts every attempt
- out_valid  out  1  p, err and retried are valid
- out_ready  in  1  consumer accepts the result
- p  out  2*WIDTH  product
- err  out  1  residue check failed on the final attempt
- retried  out  1  at least one recomputation occurred

## Operation
- States:
  - IDLE: operand accept.
  - CALC: one partial product per cycle.
  - CHECK: residue compare.
  - RETRY: clear for recomputation.
  - DONE: result presented.
- Accept: when in_valid && in_ready, latch a, b and inj.
  - Set ra = a mod 3 and rb = b mod 3.
  - Clear acc, bit index and retry count.
  - Go to CALC.
- CALC, one step per cycle: if b[i] is set, acc += a << i.
  - Width is 2*WIDTH. The sum cannot overflow because a*b < 2^(2*WIDTH).
  - After step i = WIDTH-1, go to CHECK.
- Fault injection: on the last CALC step, XOR bit 0 of acc when either condition holds.
  - inj[0] is set and this is attempt 0.
  - inj[1] is set, on any attempt.
- The injected flip changes acc mod 3 by ±1, so it is always detected.
- CHECK: compare acc mod 3 with (ra*rb) mod 3.
  - Match: go to DONE with err=0.
  - Mismatch and retry count < MAX_RETRY: increment retry count, go to RETRY.
  - Mismatch and retry count = MAX_RETRY: go to DONE with err=1. p still carries acc.
- RETRY: clear acc and the bit index, set retried=1, go to CALC.
- DONE: hold out_valid=1 with p, err and retried stable until out_ready is high. Then go to IDLE.
- In DONE, in_valid is ignored. No operand is accepted in the same cycle as the result handoff.
- A stalled output does not corrupt the result. p, err and retried are registered and held until handed off.

## Timing
- Reset (rst_n low, asynchronous) takes effect immediately:
  - state = IDLE, so in_ready=1.
  - out_valid=0, p=0, err=0, retried=0.
  - acc, the retry count and the latched inj are cleared.
- Reset asserted mid-CALC, CHECK or DONE aborts the operation. No out_valid pulse follows.
- Timing with the accept edge as cycle 0:
  - CALC occupies cycles 1..WIDTH.
  - CHECK occupies cycle WIDTH+1.
  - out_valid is high from cycle WIDTH+2.
- Each retry adds WIDTH+2 cycles (RETRY + CALC + CHECK).
- Worst case latency: (MAX_RETRY+1)*(WIDTH+2).
- Throughput, fault-free with out_ready held high: one result per WIDTH+3 cycles.
- out_valid falls in the cycle after the handoff edge, and in_ready rises in that same cycle.

## Structure
- Package mult_ft_pkg holds:
  - the state enum (IDLE, CALC, CHECK, RETRY, DONE);
  - localparam widths for acc and the bit index (clog2(WIDTH));
  - a width-generic function mod3() that reduces by summing bit pairs with weights 1 and 2.
- Sub-module mult_ft_residue3 (parameter W) is a combinational mod-3 reducer. It is instantiated three times: for a, for b, and for acc.
- The remaining logic sits in one FSM and datapath in mult_seq_ft.

## Test plan
- WIDTH=4, a=15, b=15, inj=00, out_ready=1: p=225, err=0, retried=0, out_valid at cycle 6.
- WIDTH=4, a=0, b=9, then a=9, b=0, back-to-back: both results p=0, err=0. in_ready is low between them.
- WIDTH=4, MAX_RETRY=1, a=7, b=6, inj=01: p=42, err=0, retried=1, out_valid at cycle 12.
- WIDTH=4, MAX_RETRY=1, a=7, b=6, inj=10: err=1, retried=1, p=43 (the corrupted value), out_valid at cycle 12.
- WIDTH=8, a=255, b=255, out_ready held low for 5 cycles after out_valid: p=65025 held stable throughout. Handoff happens on the first out_ready cycle, then in_ready returns.
- WIDTH=4, rst_n pulsed low during CALC cycle 2:
  - outputs return to reset values asynchronously;
  - no out_valid follows;
  - the next operation, 3*5, gives p=15.
